// File: rtl/exc_commit_ctrl_pkg.sv
// rtl/exc_commit_ctrl_pkg.sv - shared ExcCode constants, exception vector and FSM state type
package exc_commit_ctrl_pkg;

    localparam logic [4:0]  EX_INT           = 5'd0;
    localparam logic [4:0]  EX_ADEL          = 5'd4;
    localparam logic [4:0]  EX_ADES          = 5'd5;
    localparam logic [4:0]  EX_SYS           = 5'd8;
    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Only address errors report a BadVAddr to CP0.
    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EX_ADEL) || (code == EX_ADES);
    endfunction

endpackage

// File: rtl/int_sync2.sv
// rtl/int_sync2.sv - parameterised-width two-flop synchroniser with async active-low reset
module int_sync2 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - WB commit-point exception/interrupt/ERET sequencer with flush blocking
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int_in,
    output logic [5:0]  ext_int_sync,
    input  logic        c0_status_ie,
    input  logic        c0_status_exl,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    input  logic [31:0] c0_epc,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_in,
    input  logic [4:0]  wb_excode_in,
    input  logic [31:0] wb_badvaddr_in,
    input  logic        wb_eret,
    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_badvaddr,
    output logic        eret_flush,
    output logic        commit_ok,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        busy
);

    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

    state_e      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    logic        flush_d, flush_q;
    logic [31:0] flush_pc_d, flush_pc_q;

    logic        int_req;
    logic        take;
    logic        ex_sel;
    logic [4:0]  code_sel;
    logic        eret_sel;

    logic        unused_pc;
    assign unused_pc = ^wb_pc;

    int_sync2 #(.WIDTH(6)) u_int_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_int_in),
        .q      (ext_int_sync)
    );

    // Priority: interrupt > instruction exception > ERET. Gating take with resetn
    // keeps every combinational strobe low while reset is held.
    always_comb begin
        int_req  = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));
        take     = resetn & (state_q == ST_IDLE) & wb_valid;
        ex_sel   = 1'b0;
        code_sel = EX_INT;
        eret_sel = 1'b0;
        if (take) begin
            if (int_req) begin
                ex_sel   = 1'b1;
                code_sel = EX_INT;
            end else if (wb_ex_in) begin
                ex_sel   = 1'b1;
                code_sel = wb_excode_in;
            end else if (wb_eret) begin
                eret_sel = 1'b1;
            end
        end
    end

    always_comb begin
        wb_ex       = ex_sel;
        wb_excode   = code_sel;
        eret_flush  = eret_sel;
        commit_ok   = take & ~ex_sel & ~eret_sel;
        wb_badvaddr = (ex_sel && is_addr_err(code_sel)) ? wb_badvaddr_in : 32'h0;
        flush       = flush_q;
        flush_pc    = flush_pc_q;
        busy        = resetn & (state_q != ST_IDLE);
    end

    // Counter is loaded on entry to FLUSH and leaves at 1, so the block spans
    // exactly FLUSH_CYCLES cycles after the strobe cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_sel || eret_sel) begin
                    state_d    = ST_FLUSH;
                    cnt_d      = FLUSH_CNT;
                    flush_d    = 1'b1;
                    flush_pc_d = ex_sel ? EX_ENTRY : c0_epc;
                end
            end
            ST_FLUSH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            flush_q    <= 1'b0;
            flush_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

endmodule
